clic_target_pipe: RTL and testbench

- Next-generation CLIC interrupt arbiter for one hart.
- Selects the highest-ranked pending and enabled source through a binary max-tree, then hands it to the core with a valid/ready handshake.
- Generalised over the existing single-cycle / one-stage arbiter in three ways:
  - any number of pipeline stages after the tree;
  - a priority threshold filter;
  - preemption kill that fires only on a strictly higher-ranked source.
- Sits between the CLIC gateway/config registers and the core interrupt interface.

---
 rtl/clic_target_pipe.sv | 193 +++++++++++++++++++
 tb/tb_clic_target_pipe.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/clic_target_pipe.sv
// CLIC interrupt arbiter for one hart: max-tree selection, optional pipeline,
// threshold filter, valid/ready handoff to the core with strictly-higher preemption kill.
module clic_target_pipe #(
  parameter  int unsigned N_SOURCE  = 256,
  parameter  int unsigned N_PIPE    = 0,
  parameter  int unsigned PrioWidth = 8,
  parameter  int unsigned ModeWidth = 2,
  localparam int unsigned SrcWidth  = $clog2(N_SOURCE)
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [N_SOURCE-1:0]                 ip_i,
  input  logic [N_SOURCE-1:0]                 ie_i,
  input  logic [N_SOURCE-1:0]                 le_i,
  input  logic [N_SOURCE-1:0]                 shv_i,
  input  logic [N_SOURCE-1:0][PrioWidth-1:0]  prio_i,
  input  logic [N_SOURCE-1:0][ModeWidth-1:0]  mode_i,
  input  logic [PrioWidth-1:0]                thresh_i,
  output logic [N_SOURCE-1:0]                 claim_o,
  output logic                                irq_valid_o,
  input  logic                                irq_ready_i,
  output logic [SrcWidth-1:0]                 irq_id_o,
  output logic [PrioWidth-1:0]                irq_max_o,
  output logic [ModeWidth-1:0]                irq_mode_o,
  output logic                                irq_shv_o,
  output logic                                irq_kill_req_o,
  input  logic                                irq_kill_ack_i
);

  localparam int unsigned KW    = ModeWidth + PrioWidth;
  localparam int unsigned NLeaf = 1 << SrcWidth;
  localparam int unsigned HW    = $clog2(N_PIPE + 2);
  localparam logic [HW-1:0] HOLD = HW'(N_PIPE + 1);

  typedef enum logic [1:0] {IDLE, ACK, CLAIM} state_e;

  logic                root_v;
  logic [SrcWidth-1:0] root_id;
  logic [KW-1:0]       root_key;

  // Heap-ordered tree: node k combines 2k (lower ids) and 2k+1 (higher ids).
  always_comb begin : tree
    logic                node_v   [2*NLeaf];
    logic [SrcWidth-1:0] node_id  [2*NLeaf];
    logic [KW-1:0]       node_key [2*NLeaf];
    logic                pick_r;
    for (int unsigned i = 0; i < 2*NLeaf; i++) begin
      node_v[i]   = 1'b0;
      node_id[i]  = '0;
      node_key[i] = '0;
    end
    pick_r = 1'b0;
    for (int unsigned i = 0; i < NLeaf; i++) begin
      node_id[NLeaf+i] = SrcWidth'(i);
      if (i < N_SOURCE) begin
        node_v[NLeaf+i]   = ip_i[i] & ie_i[i];
        node_key[NLeaf+i] = {mode_i[i], prio_i[i]};
      end
    end
    for (int unsigned k = NLeaf - 1; k >= 1; k--) begin
      pick_r = node_v[2*k+1] && (!node_v[2*k] || (node_key[2*k+1] > node_key[2*k]));
      node_v[k]   = node_v[2*k] | node_v[2*k+1];
      node_id[k]  = pick_r ? node_id[2*k+1]  : node_id[2*k];
      node_key[k] = pick_r ? node_key[2*k+1] : node_key[2*k];
    end
    root_v   = node_v[1];
    root_id  = node_id[1];
    root_key = node_key[1];
  end

  logic                out_v;
  logic [SrcWidth-1:0] out_id;
  logic [KW-1:0]       out_key;

  generate
    if (N_PIPE == 0) begin : g_nopipe
      assign out_v   = root_v;
      assign out_id  = root_id;
      assign out_key = root_key;
    end else begin : g_pipe
      logic                pv   [N_PIPE];
      logic [SrcWidth-1:0] pid  [N_PIPE];
      logic [KW-1:0]       pkey [N_PIPE];
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int unsigned i = 0; i < N_PIPE; i++) begin
            pv[i]   <= 1'b0;
            pid[i]  <= '0;
            pkey[i] <= '0;
          end
        end else begin
          pv[0]   <= root_v;
          pid[0]  <= root_id;
          pkey[0] <= root_key;
          for (int unsigned i = 1; i < N_PIPE; i++) begin
            pv[i]   <= pv[i-1];
            pid[i]  <= pid[i-1];
            pkey[i] <= pkey[i-1];
          end
        end
      end
      assign out_v   = pv[N_PIPE-1];
      assign out_id  = pid[N_PIPE-1];
      assign out_key = pkey[N_PIPE-1];
    end
  endgenerate

  state_e              state_q, state_d;
  logic [HW-1:0]       hold_q;
  logic                kill_q, kill_d;
  logic                latch;
  logic [SrcWidth-1:0] id_q;
  logic [KW-1:0]       key_q;
  logic                shv_q;
  logic                eligible;

  // Threshold is applied to the live pipe output; holdoff hides stale copies after a claim.
  assign eligible = out_v && (out_key[PrioWidth-1:0] > thresh_i) && (hold_q == '0);

  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    latch   = 1'b0;
    case (state_q)
      IDLE: begin
        kill_d = 1'b0;
        if (eligible) begin
          latch   = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        if (!le_i[id_q] && !ip_i[id_q]) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end else if (irq_ready_i) begin
          state_d = CLAIM;
          kill_d  = 1'b0;
        end else if (kill_q && irq_kill_ack_i) begin
          state_d = IDLE;
          kill_d  = 1'b0;
        end else if (eligible && (out_key > key_q)) begin
          kill_d = 1'b1;
        end
      end
      CLAIM: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
      hold_q  <= '0;
      id_q    <= '0;
      key_q   <= '0;
      shv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (state_q == CLAIM) begin
        hold_q <= HOLD;
      end else if (hold_q != '0) begin
        hold_q <= hold_q - 1'b1;
      end
      if (latch) begin
        id_q  <= out_id;
        key_q <= out_key;
        shv_q <= shv_i[out_id];
      end
    end
  end

  assign irq_valid_o    = (state_q == ACK);
  assign irq_kill_req_o = kill_q;
  assign irq_id_o       = id_q;
  assign irq_max_o      = key_q[PrioWidth-1:0];
  assign irq_mode_o     = key_q[KW-1:PrioWidth];
  assign irq_shv_o      = shv_q;
  assign claim_o        = (state_q == CLAIM) ? (N_SOURCE'(1) << id_q) : '0;

  assert property (@(posedge clk_i) (N_SOURCE >= 2) && (N_PIPE <= 8));
  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(claim_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(irq_valid_o && (|claim_o)));

endmodule

// File: tb/tb_clic_target_pipe.sv
// Directed bench for clic_target_pipe with 16 sources and two pipe stages.
module tb_clic_target_pipe;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [15:0]      ip, ie, le, shv;
  logic [15:0][7:0] prio;
  logic [15:0][1:0] mode;
  logic [7:0]       thresh;
  logic [15:0]      claim;
  logic             valid, ready, kill_req, kill_ack, irq_shv;
  logic [3:0]       id;
  logic [7:0]       max;
  logic [1:0]       irq_mode;

  int n_checks = 0;
  int n_fail   = 0;

  clic_target_pipe #(.N_SOURCE(16), .N_PIPE(2), .PrioWidth(8), .ModeWidth(2)) dut (
    .clk_i(clk), .rst_ni(rst_n), .ip_i(ip), .ie_i(ie), .le_i(le), .shv_i(shv),
    .prio_i(prio), .mode_i(mode), .thresh_i(thresh), .claim_o(claim),
    .irq_valid_o(valid), .irq_ready_i(ready), .irq_id_o(id), .irq_max_o(max),
    .irq_mode_o(irq_mode), .irq_shv_o(irq_shv), .irq_kill_req_o(kill_req),
    .irq_kill_ack_i(kill_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_src(input int s, input int p, input int m, input logic l);
    ip[s]   = 1'b1;
    ie[s]   = 1'b1;
    prio[s] = 8'(p);
    mode[s] = 2'(m);
    le[s]   = l;
  endtask

  task automatic clear_in;
    ip = '0; ie = '0; le = '0; shv = '0; prio = '0; mode = '0;
    thresh = '0; ready = 1'b0; kill_ack = 1'b0;
  endtask

  task automatic quiet;
    clear_in();
    tick(8);
    check("quiet_valid", valid, 0);
    check("quiet_kill", kill_req, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, valid, 0);
    check({tag, "_kill"}, kill_req, 0);
    check({tag, "_claim"}, claim, 0);
    check({tag, "_id"}, id, 0);
    check({tag, "_max"}, max, 0);
    check({tag, "_mode"}, irq_mode, 0);
    check({tag, "_shv"}, irq_shv, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    clear_in();
    tick(2);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Basic latency, claim and holdoff
    set_src(5, 3, 3, 1'b0);
    shv[5] = 1'b1;
    tick(2);
    check("lat_c2_valid", valid, 0);
    tick();
    check("lat_c3_valid", valid, 1);
    check("lat_id", id, 5);
    check("lat_max", max, 3);
    check("lat_mode", irq_mode, 3);
    check("lat_shv", irq_shv, 1);
    tick();
    ready = 1'b1;
    tick();
    check("claim_c5", claim, 16'h0020);
    check("claim_c5_valid", valid, 0);
    ready = 1'b0;
    for (int c = 6; c <= 9; c++) begin
      tick();
      check("holdoff_valid", valid, 0);
      check("holdoff_claim", claim, 0);
    end
    tick();
    check("revalid_c10", valid, 1);
    quiet();

    // Tie and mode ranking
    set_src(7, 4, 3, 1'b0);
    set_src(2, 4, 3, 1'b0);
    tick(3);
    check("tie_valid", valid, 1);
    check("tie_id", id, 2);
    quiet();
    set_src(9, 1, 3, 1'b0);
    set_src(4, 200, 1, 1'b0);
    tick(3);
    check("mode_id", id, 9);
    check("mode_max", max, 1);
    check("mode_mode", irq_mode, 3);
    quiet();

    // Threshold
    thresh = 8'd10;
    set_src(1, 10, 0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("thresh_eq_valid", valid, 0);
    end
    prio[1] = 8'd11;
    tick(2);
    check("thresh_c2_valid", valid, 0);
    tick();
    check("thresh_c3_valid", valid, 1);
    check("thresh_id", id, 1);
    check("thresh_max", max, 11);
    quiet();

    // Preemption kill
    set_src(3, 5, 0, 1'b0);
    tick(3);
    check("kill_base_id", id, 3);
    check("kill_base_req", kill_req, 0);
    set_src(8, 5, 0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("kill_equal_req", kill_req, 0);
    end
    prio[8] = 8'd6;
    tick(2);
    check("kill_c2_req", kill_req, 0);
    tick();
    check("kill_c3_req", kill_req, 1);
    check("kill_c3_id", id, 3);
    check("kill_c3_valid", valid, 1);
    kill_ack = 1'b1;
    tick();
    check("kill_ack_valid", valid, 0);
    check("kill_ack_req", kill_req, 0);
    check("kill_ack_claim", claim, 0);
    kill_ack = 1'b0;
    tick();
    check("kill_new_valid", valid, 1);
    check("kill_new_id", id, 8);
    check("kill_new_max", max, 6);
    set_src(10, 7, 0, 1'b0);
    tick(3);
    check("kill2_req", kill_req, 1);
    check("kill2_id", id, 8);
    ready = 1'b1;
    kill_ack = 1'b1;
    tick();
    check("ready_wins_claim", claim, 16'h0100);
    check("ready_wins_kill", kill_req, 0);
    check("ready_wins_valid", valid, 0);
    ready = 1'b0;
    kill_ack = 1'b0;
    quiet();

    // Level-triggered withdraw and edge-triggered hold
    set_src(6, 2, 0, 1'b0);
    tick(3);
    check("level_valid", valid, 1);
    ip[6] = 1'b0;
    tick();
    check("level_drop_valid", valid, 0);
    check("level_drop_claim", claim, 0);
    quiet();
    set_src(6, 2, 0, 1'b1);
    tick(3);
    check("edge_valid", valid, 1);
    ip[6] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("edge_hold_valid", valid, 1);
      check("edge_hold_id", id, 6);
    end
    ready = 1'b1;
    tick();
    check("edge_claim", claim, 16'h0040);
    ready = 1'b0;
    quiet();

    // Asynchronous reset during ACK with kill pending
    set_src(3, 5, 0, 1'b0);
    tick(3);
    set_src(8, 6, 0, 1'b0);
    tick(3);
    check("rst_pre_kill", kill_req, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    tick(2);
    check("rst_hold_claim", claim, 0);
    rst_n = 1'b1;
    tick(2);
    check("rst_rel_c2_valid", valid, 0);
    check("rst_rel_c2_claim", claim, 0);
    tick();
    check("rst_rel_c3_valid", valid, 1);
    check("rst_rel_c3_id", id, 8);
    ready = 1'b1;
    tick();
    check("rst_rel_claim", claim, 16'h0100);
    ready = 1'b0;
    quiet();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
